// File: rtl/mul_reg_bank.sv
// Multi-channel signed fixed-point operand register bank with per-entry valid bits,
// overwrite/saturating-accumulate writes and registered, optionally consuming reads.
module mul_reg_bank #(
  parameter int I_WIDTH     = 8,
  parameter int F_WIDTH     = 8,
  parameter int DEPTH       = 2,
  parameter int CH          = 4,
  parameter int ADDRS_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CH_WIDTH    = (CH > 1) ? $clog2(CH) : 1,
  parameter int CNT_WIDTH   = $clog2(CH * DEPTH + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  mreg_rst_i,
  input  logic                                  mreg_clr_i,
  input  logic                                  mreg_wr_en_i,
  input  logic                                  mreg_wr_acc_i,
  input  logic [CH_WIDTH-1:0]                   mreg_wr_ch_i,
  input  logic [ADDRS_WIDTH-1:0]                mreg_wr_addrs_i,
  input  logic signed [I_WIDTH+F_WIDTH-1:0]     wr_data_i,
  input  logic                                  mreg_rd_en_i,
  input  logic                                  mreg_rd_consume_i,
  input  logic [CH_WIDTH-1:0]                   mreg_rd_ch_i,
  input  logic [ADDRS_WIDTH-1:0]                mreg_rd_addrs_i,
  output logic signed [I_WIDTH+F_WIDTH-1:0]     rd_data_o,
  output logic                                  rd_valid_o,
  output logic                                  ovf_o,
  output logic [CNT_WIDTH-1:0]                  count_o,
  output logic                                  full_o,
  output logic                                  empty_o
);

  localparam int DW = I_WIDTH + F_WIDTH;
  localparam int N  = CH * DEPTH;

  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  // Clamp a DW+1-bit sum back into the DW-bit signed range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW:0] s);
    if (s[DW] != s[DW-1]) begin
      sat_dw = s[DW] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_dw = s[DW-1:0];
    end
  endfunction

  function automatic logic sat_hit(input logic signed [DW:0] s);
    sat_hit = (s[DW] != s[DW-1]);
  endfunction

  logic signed [DW-1:0]  data_q [N];
  logic signed [DW-1:0]  data_d [N];
  logic [N-1:0]          vld_q, vld_d;
  logic signed [DW-1:0]  rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [N-1:0]          wr_sel, rd_sel;
  logic                  wr_hit, rd_hit;
  logic signed [DW-1:0]  wr_old, rd_word, wr_new;
  logic                  wr_old_vld, rd_old_vld;
  logic signed [DW:0]    wr_sum;
  logic                  acc_live, set_new, cons_hit;

  // Address decode: out-of-range channel/address selects nothing.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int c = 0; c < CH; c++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (mreg_wr_ch_i == CH_WIDTH'(c) && mreg_wr_addrs_i == ADDRS_WIDTH'(a)) begin
          wr_sel[c*DEPTH+a] = 1'b1;
        end
        if (mreg_rd_ch_i == CH_WIDTH'(c) && mreg_rd_addrs_i == ADDRS_WIDTH'(a)) begin
          rd_sel[c*DEPTH+a] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_old     = '0;
    wr_old_vld = 1'b0;
    rd_word    = '0;
    rd_old_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (wr_sel[i]) begin
        wr_old     = data_q[i];
        wr_old_vld = vld_q[i];
      end
      if (rd_sel[i]) begin
        rd_word    = data_q[i];
        rd_old_vld = vld_q[i];
      end
    end
  end

  assign wr_hit   = mreg_wr_en_i && (|wr_sel);
  assign rd_hit   = mreg_rd_en_i && (|rd_sel);
  assign wr_sum   = {wr_old[DW-1], wr_old} + {wr_data_i[DW-1], wr_data_i};
  assign acc_live = mreg_wr_acc_i && wr_old_vld;
  assign wr_new   = acc_live ? sat_dw(wr_sum) : wr_data_i;
  assign set_new  = wr_hit && !wr_old_vld;
  // A consume that collides with a write to the same entry loses to the write.
  assign cons_hit = rd_hit && mreg_rd_consume_i && rd_old_vld
                    && !(wr_hit && (|(wr_sel & rd_sel)));

  always_comb begin
    data_d     = data_q;
    vld_d      = vld_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    count_d    = count_q;
    if (mreg_clr_i) begin
      for (int i = 0; i < N; i++) begin
        data_d[i] = '0;
      end
      vld_d     = '0;
      rd_data_d = '0;
      ovf_d     = 1'b0;
      count_d   = '0;
    end else begin
      if (mreg_rd_en_i) begin
        rd_data_d  = rd_hit ? rd_word : '0;
        rd_valid_d = rd_hit && rd_old_vld;
      end
      for (int i = 0; i < N; i++) begin
        if (mreg_wr_en_i && wr_sel[i]) begin
          data_d[i] = wr_new;
          vld_d[i]  = 1'b1;
        end else if (mreg_rd_en_i && mreg_rd_consume_i && rd_sel[i]) begin
          vld_d[i] = 1'b0;
        end
      end
      if (wr_hit && acc_live && sat_hit(wr_sum)) begin
        ovf_d = 1'b1;
      end
      count_d = count_q + CNT_WIDTH'(set_new) - CNT_WIDTH'(cons_hit);
    end
  end

  always_ff @(posedge clk_i or posedge mreg_rst_i) begin
    if (mreg_rst_i) begin
      for (int i = 0; i < N; i++) begin
        data_q[i] <= '0;
      end
      vld_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      data_q     <= data_d;
      vld_q      <= vld_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign ovf_o      = ovf_q;
  assign count_o    = count_q;
  assign full_o     = (count_q == CNT_WIDTH'(N));
  assign empty_o    = (count_q == '0);

endmodule

// File: tb/tb_mul_reg_bank.sv
// Directed bench for mul_reg_bank: default 4x2 bank plus a DEPTH=3 instance for out-of-range addressing.
module tb_mul_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;

  // Instance A: CH=4, DEPTH=2
  logic        clr, we, acc, re, cons;
  logic [1:0]  wch, rch;
  logic        wa, ra;
  logic [15:0] wd;
  logic [15:0] rdata;
  logic        rvld, ovf, full, empty;
  logic [3:0]  count;

  // Instance B: CH=4, DEPTH=3
  logic        b_clr, b_we, b_acc, b_re, b_cons;
  logic [1:0]  b_wch, b_rch, b_wa, b_ra;
  logic [15:0] b_wd;
  logic [15:0] b_rdata;
  logic        b_rvld, b_ovf, b_full, b_empty;
  logic [3:0]  b_count;

  always #5 clk = ~clk;

  mul_reg_bank u_dut (
    .clk_i(clk), .mreg_rst_i(rst), .mreg_clr_i(clr),
    .mreg_wr_en_i(we), .mreg_wr_acc_i(acc), .mreg_wr_ch_i(wch), .mreg_wr_addrs_i(wa),
    .wr_data_i(wd), .mreg_rd_en_i(re), .mreg_rd_consume_i(cons), .mreg_rd_ch_i(rch),
    .mreg_rd_addrs_i(ra), .rd_data_o(rdata), .rd_valid_o(rvld), .ovf_o(ovf),
    .count_o(count), .full_o(full), .empty_o(empty)
  );

  mul_reg_bank #(.DEPTH(3)) u_dut3 (
    .clk_i(clk), .mreg_rst_i(rst), .mreg_clr_i(b_clr),
    .mreg_wr_en_i(b_we), .mreg_wr_acc_i(b_acc), .mreg_wr_ch_i(b_wch), .mreg_wr_addrs_i(b_wa),
    .wr_data_i(b_wd), .mreg_rd_en_i(b_re), .mreg_rd_consume_i(b_cons), .mreg_rd_ch_i(b_rch),
    .mreg_rd_addrs_i(b_ra), .rd_data_o(b_rdata), .rd_valid_o(b_rvld), .ovf_o(b_ovf),
    .count_o(b_count), .full_o(b_full), .empty_o(b_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic ac, input logic [1:0] wc, input logic wadr,
                     input logic [15:0] d, input logic r, input logic cn, input logic [1:0] rc,
                     input logic radr, input logic cl);
    we = w; acc = ac; wch = wc; wa = wadr; wd = d;
    re = r; cons = cn; rch = rc; ra = radr; clr = cl;
    @(posedge clk); #1;
    we = 1'b0; acc = 1'b0; re = 1'b0; cons = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [1:0] c, input logic a, input logic [15:0] d);
    cyc(1'b1, 1'b0, c, a, d, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic ac(input logic [1:0] c, input logic a, input logic [15:0] d);
    cyc(1'b1, 1'b1, c, a, d, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] c, input logic a, input logic cn);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b1, cn, c, a, 1'b0);
  endtask

  task automatic clear();
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic cycb(input logic w, input logic acb, input logic [1:0] wc, input logic [1:0] wadr,
                      input logic [15:0] d, input logic r, input logic [1:0] rc, input logic [1:0] radr);
    b_we = w; b_acc = acb; b_wch = wc; b_wa = wadr; b_wd = d;
    b_re = r; b_rch = rc; b_ra = radr;
    @(posedge clk); #1;
    b_we = 1'b0; b_acc = 1'b0; b_re = 1'b0;
  endtask

  initial begin
    clr = 0; we = 0; acc = 0; re = 0; cons = 0; wch = 0; rch = 0; wa = 0; ra = 0; wd = 0;
    b_clr = 0; b_we = 0; b_acc = 0; b_re = 0; b_cons = 0; b_wch = 0; b_rch = 0;
    b_wa = 0; b_ra = 0; b_wd = 0;

    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rvld", rvld, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Overwrite and read latency
    wr(2'd2, 1'b1, 16'h1234);
    chk("ow_count", count, 1);
    chk("ow_empty", empty, 0);
    rd(2'd2, 1'b1, 1'b0);
    chk("ow_rdata", rdata, 16'h1234);
    chk("ow_rvld", rvld, 1);
    @(posedge clk); #1;
    chk("idle_rvld", rvld, 0);
    chk("idle_rdata_hold", rdata, 16'h1234);

    // Accumulate with positive saturation
    wr(2'd1, 1'b0, 16'h7000);
    chk("acc_count_pre", count, 2);
    ac(2'd1, 1'b0, 16'h2000);
    chk("acc_ovf", ovf, 1);
    chk("acc_count", count, 2);
    rd(2'd1, 1'b0, 1'b0);
    chk("acc_sat_pos", rdata, 16'h7FFF);
    clear();
    chk("clr_ovf", ovf, 0);
    chk("clr_count", count, 0);
    chk("clr_rdata", rdata, 0);
    chk("clr_empty", empty, 1);

    // Accumulate onto invalid entry, then non-saturating and negative-saturating sums
    ac(2'd0, 1'b0, 16'hFFFB);
    chk("acc_inv_count", count, 1);
    rd(2'd0, 1'b0, 1'b0);
    chk("acc_inv_data", rdata, 16'hFFFB);
    chk("acc_inv_vld", rvld, 1);
    ac(2'd0, 1'b0, 16'h0008);
    rd(2'd0, 1'b0, 1'b0);
    chk("acc_add", rdata, 16'h0003);
    chk("acc_add_ovf", ovf, 0);
    ac(2'd0, 1'b0, 16'h8000);
    rd(2'd0, 1'b0, 1'b0);
    chk("acc_neg_nosat", rdata, 16'h8003);
    chk("acc_neg_nosat_ovf", ovf, 0);
    ac(2'd0, 1'b0, 16'hFFF0);
    rd(2'd0, 1'b0, 1'b0);
    chk("acc_sat_neg", rdata, 16'h8000);
    chk("acc_sat_neg_ovf", ovf, 1);

    // Fill whole bank, consume one entry
    clear();
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < 2; a++) begin
        wr(2'(c), 1'(a), 16'h0100 + 16'(c * 2 + a));
      end
    end
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);
    wr(2'd1, 1'b1, 16'h0BEE);
    chk("full_wr_count", count, 8);
    rd(2'd3, 1'b1, 1'b1);
    chk("cons_rdata", rdata, 16'h0107);
    chk("cons_rvld", rvld, 1);
    chk("cons_count", count, 7);
    chk("cons_full", full, 0);
    rd(2'd3, 1'b1, 1'b0);
    chk("reread_rvld", rvld, 0);
    chk("reread_rdata", rdata, 16'h0107);

    // Read-before-write collision with consume: write wins
    wr(2'd0, 1'b1, 16'h00AA);
    chk("coll_pre_count", count, 7);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 16'h0055, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    chk("coll_rdata", rdata, 16'h00AA);
    chk("coll_rvld", rvld, 1);
    chk("coll_count", count, 7);
    rd(2'd0, 1'b1, 1'b0);
    chk("coll_after_data", rdata, 16'h0055);
    chk("coll_after_vld", rvld, 1);

    // Write to an invalid entry while consuming a different valid one
    cyc(1'b1, 1'b0, 2'd3, 1'b1, 16'h0777, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("wr_cons_rdata", rdata, 16'h0100);
    chk("wr_cons_count", count, 7);

    // Clear together with write and read
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 16'h1111, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
    chk("clrwr_count", count, 0);
    chk("clrwr_rvld", rvld, 0);
    chk("clrwr_rdata", rdata, 0);
    rd(2'd2, 1'b0, 1'b0);
    chk("clrwr_entry", rdata, 0);
    chk("clrwr_entry_vld", rvld, 0);

    // Asynchronous reset mid-traffic
    wr(2'd0, 1'b0, 16'h7000);
    wr(2'd1, 1'b0, 16'h0001);
    wr(2'd2, 1'b0, 16'h0002);
    ac(2'd0, 1'b0, 16'h2000);
    chk("prerst_count", count, 3);
    chk("prerst_ovf", ovf, 1);
    re = 1'b1; rch = 2'd1; ra = 1'b0;
    @(posedge clk); #1;
    chk("prerst_rdata", rdata, 16'h0001);
    we = 1'b1; wch = 2'd3; wa = 1'b0; wd = 16'h0AAA;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_rvld", rvld, 0);
    we = 1'b0; re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd(2'd0, 1'b0, 1'b0);
    chk("postrst_rdata", rdata, 0);
    chk("postrst_rvld", rvld, 0);

    // Out-of-range addressing on the DEPTH=3 bank
    cycb(1'b1, 1'b0, 2'd1, 2'd2, 16'h4242, 1'b0, 2'd0, 2'd0);
    chk("oor_pre_count", b_count, 1);
    cycb(1'b1, 1'b0, 2'd1, 2'd3, 16'h9999, 1'b0, 2'd0, 2'd0);
    chk("oor_wr_count", b_count, 1);
    cycb(1'b1, 1'b1, 2'd1, 2'd3, 16'h7FFF, 1'b0, 2'd0, 2'd0);
    chk("oor_acc_ovf", b_ovf, 0);
    cycb(1'b0, 1'b0, 2'd0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd2);
    chk("oor_keep_data", b_rdata, 16'h4242);
    chk("oor_keep_vld", b_rvld, 1);
    cycb(1'b0, 1'b0, 2'd0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd3);
    chk("oor_rd_data", b_rdata, 0);
    chk("oor_rd_vld", b_rvld, 0);
    cycb(1'b0, 1'b0, 2'd0, 2'd0, 16'h0, 1'b1, 2'd2, 2'd0);
    chk("oor_alias_data", b_rdata, 0);
    chk("oor_alias_vld", b_rvld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
